ubus_master: RTL and testbench
==============================

UBUS_MASTER -- requirements
Module: ubus_master

Interface
REQ-001 Parameter MAX_WAIT, default 16: maximum consecutive ubus_wait-high cycles per beat before the transfer is aborted.
REQ-002 ubus_clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 ubus_reset_n  input  1  asynchronous, active-low reset.
REQ-004 cmd_valid  input  1  local transfer request.
REQ-005 cmd_ready  output  1  block can accept a command.
REQ-006 cmd_write  input  1  1 = write, 0 = read.
REQ-007 cmd_addr  input  16  transfer start address.
REQ-008 cmd_size  input  2  beats = 1, 2, 4 or 8 for codes 0, 1, 2, 3.
REQ-009 cmd_wdata  input  64  write bytes; beat i uses bits [8i+7:8i].
REQ-010 rsp_valid  output  1  one-cycle completion pulse.
REQ-011 rsp_rdata  output  64  read bytes, same lane mapping as cmd_wdata; unused lanes 0.
REQ-012 rsp_error  output  1  error or timeout occurred; valid with rsp_valid.
REQ-013 ubus_req  output  1  bus request to the arbiter.
REQ-014 ubus_gnt  input  1  grant from the arbiter.
REQ-015 ubus_start  input  1  arbitration-cycle marker from the arbiter.
REQ-016 ubus_addr  output(tri)  16  address; driven in ADDR only.
REQ-017 ubus_size  output(tri)  2  size; driven in ADDR only.
REQ-018 ubus_read, ubus_write  output(tri)  1 each  direction; driven in ADDR only.
REQ-019 ubus_bip  output(tri)  1  burst in progress; driven in DATA only.
REQ-020 ubus_data  inout  8  driven only in DATA on write transfers; high-Z otherwise.
REQ-021 ubus_wait, ubus_error  input  1 each  slave wait and error.

Function
REQ-022 FSM states: IDLE, REQ, ADDR, DATA, RESP.
REQ-023 Transitions:
- IDLE: cmd_ready=1; cmd_valid captures all cmd_* into holding registers -> REQ.
- REQ: ubus_req=1; ubus_gnt=1 and ubus_start=1 sampled together -> ADDR.
- ADDR: exactly one cycle; ubus_req=0; beat counter and wait counter cleared -> DATA.
- DATA: runs until the last beat completes or timeout -> RESP.
- RESP: one cycle -> IDLE.
REQ-024 ubus_gnt without ubus_start in REQ is ignored; the block holds ubus_req until both are high in the same cycle.
REQ-025 ADDR drives ubus_addr=captured addr, ubus_size=captured size, ubus_write=captured write, ubus_read=~captured write.
REQ-026 DATA, bip: ubus_bip=1 on every beat except the last beat, where it is 0.
REQ-027 DATA, beat completion: a beat completes in a cycle with ubus_wait=0.
REQ-028 DATA, write data: ubus_data carries byte[beat] for the whole beat.
REQ-029 DATA, read data: ubus_data is sampled into lane[beat] at beat completion.
REQ-030 DATA, error: ubus_error=1 at any beat completion sets a sticky error flag; the transfer still runs all beats.
REQ-031 DATA, timeout: if ubus_wait stays 1 for MAX_WAIT consecutive cycles on a beat, the block drives ubus_bip=0 for one cycle, sets the error flag, then moves to RESP.
REQ-032 Transfer latency (DATA entry to RESP) = beats + total wait cycles.
REQ-033 RESP: rsp_valid=1 for one cycle, carrying rsp_rdata and rsp_error; cmd_ready=0.
REQ-034 rsp_rdata for a write transfer reads 0.
REQ-035 A new command is accepted only in IDLE, so at most one transfer is outstanding.
REQ-036 cmd_valid outside IDLE is not captured.
REQ-037 The wait counter saturates and never wraps; the beat counter is 3 bits and never exceeds beats-1.

Reset
REQ-038 While ubus_reset_n=0, state and outputs take these values immediately:
- state=IDLE
- cmd_ready=1
- rsp_valid=0, rsp_error=0, rsp_rdata=0
- ubus_req=0
- all tri-state outputs and ubus_data released to high-Z
- holding registers and counters cleared
REQ-039 Reset during any state aborts the transfer with no rsp_valid pulse.

Verification
REQ-040 Single-byte write, addr 0x1234, wdata 0xA5, gnt+start two cycles after req, no wait:
- ADDR drives 0x1234 / size 0 / write=1.
- One DATA cycle with data 0xA5 and bip=0.
- rsp_valid with rsp_error=0.
REQ-041 8-beat read, slave returns 0x01..0x08 with wait=1 for 2 cycles on beat 3:
- bip is 1 for beats 0-6 and 0 on beat 7.
- rsp_rdata=0x0807060504030201.
- DATA lasts 10 cycles.
REQ-042 4-beat write with ubus_error=1 on beat 1: all 4 beats complete, then rsp_error=1.
REQ-043 ubus_wait held high for 16 cycles on beat 0 of a 2-beat read:
- bip=0 for one cycle after timeout.
- rsp_error=1.
- Return to IDLE.
REQ-044 gnt=1 with start=0 for 3 cycles, then both high: ADDR is entered only in the cycle after both are high.
REQ-045 ubus_reset_n asserted during DATA of a write:
- ubus_data goes high-Z and ubus_req=0 asynchronously.
- No rsp_valid pulse.
- cmd_ready=1 after release.

Source files
------------

// File: rtl/ubus_master.sv
// ubus_master: single-outstanding ubus bus master.
// Arbitrates, drives one address phase, then runs 1-8 byte beats.
module ubus_master #(
  parameter int MAX_WAIT = 16
) (
  input  logic        ubus_clock,
  input  logic        ubus_reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [15:0] cmd_addr,
  input  logic [1:0]  cmd_size,
  input  logic [63:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [63:0] rsp_rdata,
  output logic        rsp_error,
  output logic        ubus_req,
  input  logic        ubus_gnt,
  input  logic        ubus_start,
  output logic [15:0] ubus_addr,
  output logic [1:0]  ubus_size,
  output logic        ubus_read,
  output logic        ubus_write,
  output logic        ubus_bip,
  inout  wire  [7:0]  ubus_data,
  input  logic        ubus_wait,
  input  logic        ubus_error
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WLIM = WW'(MAX_WAIT - 1);
  localparam logic [WW-1:0] WSAT = WW'(MAX_WAIT);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ADDR,
    DATA,
    RESP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic          write_q;
  logic [15:0]   addr_q;
  logic [1:0]    size_q;
  logic [63:0]   wdata_q;
  logic [63:0]   rdata_q;
  logic [2:0]    beat;
  logic [2:0]    last;
  logic [WW-1:0] wait_cnt;
  logic          tout;
  logic          err;
  logic          in_data;
  logic          capture;
  logic          beat_done;
  logic          tout_hit;

  assign last      = 3'((4'd1 << size_q) - 4'd1);
  assign in_data   = (state == DATA);
  assign capture   = (state == IDLE) && cmd_valid;
  assign beat_done = in_data && !tout && !ubus_wait;
  assign tout_hit  = in_data && !tout && ubus_wait &&
                     (wait_cnt == WLIM);

  // state register
  always_ff @(posedge ubus_clock or negedge ubus_reset_n) begin
    if (!ubus_reset_n) state <= IDLE;
    else               state <= state_nxt;
  end

  // next-state and registered-state-derived outputs
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_error = 1'b0;
    rsp_rdata = '0;
    ubus_req  = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = REQ;
      end
      REQ: begin
        ubus_req = 1'b1;
        if (ubus_gnt && ubus_start) state_nxt = ADDR;
      end
      ADDR: state_nxt = DATA;
      DATA: begin
        if (tout || (beat_done && beat == last))
          state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_error = err;
        rsp_rdata = write_q ? '0 : rdata_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // bus drivers: address phase, data phase, released otherwise
  assign ubus_addr  = (state == ADDR) ? addr_q : 'z;
  assign ubus_size  = (state == ADDR) ? size_q : 'z;
  assign ubus_write = (state == ADDR) ? write_q : 1'bz;
  assign ubus_read  = (state == ADDR) ? !write_q : 1'bz;
  assign ubus_bip   = in_data ? (!tout && beat != last) : 1'bz;
  assign ubus_data  = (in_data && write_q) ?
                      wdata_q[{beat, 3'b000} +: 8] : 'z;

  // command holding registers and read lane assembly
  always_ff @(posedge ubus_clock or negedge ubus_reset_n) begin
    if (!ubus_reset_n) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else if (capture) begin
      write_q <= cmd_write;
      addr_q  <= cmd_addr;
      size_q  <= cmd_size;
      wdata_q <= cmd_wdata;
      rdata_q <= '0;
    end else if (beat_done && !write_q) begin
      rdata_q[{beat, 3'b000} +: 8] <= ubus_data;
    end
  end

  // beat and wait counters, timeout and sticky error flags
  always_ff @(posedge ubus_clock or negedge ubus_reset_n) begin
    if (!ubus_reset_n) begin
      beat     <= '0;
      wait_cnt <= '0;
      tout     <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (state == ADDR) begin
        beat     <= '0;
        wait_cnt <= '0;
        tout     <= 1'b0;
      end else if (beat_done) begin
        if (beat != last) beat <= beat + 3'd1;
        wait_cnt <= '0;
      end else if (in_data && !tout && ubus_wait) begin
        if (wait_cnt != WSAT) wait_cnt <= wait_cnt + WW'(1);
        if (tout_hit) tout <= 1'b1;
      end
      if (capture)
        err <= 1'b0;
      else if ((beat_done && ubus_error) || tout_hit)
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ubus_master.sv
// tb_ubus_master: vector table, reset sequences and random
// transfers against a cycle-list model of the ubus protocol.
module tb_ubus_master;

  localparam int MW = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [15:0] cmd_addr;
  logic [1:0]  cmd_size;
  logic [63:0] cmd_wdata;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_error;
  logic        ubus_req;
  logic        ubus_gnt;
  logic        ubus_start;
  wire  [15:0] ubus_addr;
  wire  [1:0]  ubus_size;
  wire         ubus_read;
  wire         ubus_write;
  wire         ubus_bip;
  wire  [7:0]  ubus_data;
  logic        ubus_wait;
  logic        ubus_error;
  logic        sdrv;
  logic [7:0]  sval;

  assign ubus_data = sdrv ? sval : 8'bz;

  always #5 clk = ~clk;

  ubus_master #(.MAX_WAIT(MW)) dut (
    .ubus_clock  (clk),
    .ubus_reset_n(rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_size    (cmd_size),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_error   (rsp_error),
    .ubus_req    (ubus_req),
    .ubus_gnt    (ubus_gnt),
    .ubus_start  (ubus_start),
    .ubus_addr   (ubus_addr),
    .ubus_size   (ubus_size),
    .ubus_read   (ubus_read),
    .ubus_write  (ubus_write),
    .ubus_bip    (ubus_bip),
    .ubus_data   (ubus_data),
    .ubus_wait   (ubus_wait),
    .ubus_error  (ubus_error)
  );

  int errors = 0;
  int checks = 0;

  int w_sched[8];
  bit e_sched[8];
  int exp_bip[$];
  int exp_wd[$];

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [1:0]  size;
    logic [63:0] wdata;
    logic [63:0] rbytes;
    int          wbeat;
    int          wlen;
    int          ebeat;
    int          gdly;
    int          gonly;
    logic [63:0] erd;
    bit          eerr;
    int          ecyc;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // per-cycle expectations built from beats, waits and timeout rule
  task automatic model_xfer(input bit wr, input logic [1:0] size,
                            input logic [63:0] wdata,
                            input logic [63:0] rbytes,
                            output logic [63:0] rd, output bit er,
                            output int cyc);
    int beats;
    beats = 1 << size;
    rd = '0;
    er = 1'b0;
    exp_bip.delete();
    exp_wd.delete();
    for (int b = 0; b < beats; b++) begin
      int bip_v;
      int byte_v;
      bip_v  = (b != beats - 1) ? 1 : 0;
      byte_v = wr ? int'(wdata[8*b +: 8]) : -1;
      if (w_sched[b] >= MW) begin
        for (int k = 0; k < MW; k++) begin
          exp_bip.push_back(bip_v);
          exp_wd.push_back(byte_v);
        end
        exp_bip.push_back(0);
        exp_wd.push_back(-1);
        er = 1'b1;
        break;
      end
      for (int k = 0; k <= w_sched[b]; k++) begin
        exp_bip.push_back(bip_v);
        exp_wd.push_back(byte_v);
      end
      if (e_sched[b]) er = 1'b1;
      if (!wr) rd[8*b +: 8] = rbytes[8*b +: 8];
    end
    cyc = exp_bip.size();
  endtask

  task automatic run_xfer(input bit wr, input logic [15:0] addr,
                          input logic [1:0] size,
                          input logic [63:0] wdata,
                          input logic [63:0] rbytes,
                          input int gdly, input int gonly,
                          input bit noise,
                          output logic [63:0] rd, output bit er,
                          output int cyc);
    int sb;
    int sw;
    int beats;
    bit done;
    beats = 1 << size;
    sb = 0;
    sw = 0;
    cyc = 0;
    done = 1'b0;
    rd = '0;
    er = 1'b0;
    chk("idle_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_size  = size;
    cmd_wdata = wdata;
    @(negedge clk);
    if (noise) begin
      cmd_write = ~wr;
      cmd_addr  = ~addr;
      cmd_size  = ~size;
      cmd_wdata = ~wdata;
    end else begin
      cmd_valid = 1'b0;
    end
    chk("req_on", ubus_req, 1);
    chk("busy_ready", cmd_ready, 0);
    repeat (gdly) @(negedge clk);
    for (int i = 0; i < gonly; i++) begin
      ubus_gnt = 1'b1;
      ubus_start = 1'b0;
      @(negedge clk);
      chk("gnt_no_start_req", ubus_req, 1);
    end
    ubus_gnt = 1'b1;
    ubus_start = 1'b1;
    @(negedge clk);
    ubus_gnt = 1'b0;
    ubus_start = 1'b0;
    chk("addr", ubus_addr, addr);
    chk("size", ubus_size, size);
    chk("write", ubus_write, wr);
    chk("read", ubus_read, !wr);
    chk("req_off", ubus_req, 0);
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        done = 1'b1;
        rd = rsp_rdata;
        er = rsp_error;
        chk("resp_ready", cmd_ready, 0);
      end else begin
        if (cyc < exp_bip.size()) begin
          chk("bip", ubus_bip, exp_bip[cyc]);
          if (exp_wd[cyc] >= 0) chk("wbyte", ubus_data, exp_wd[cyc]);
        end
        cyc++;
        if (sb < beats) begin
          if (sw < w_sched[sb]) begin
            ubus_wait = 1'b1;
            ubus_error = 1'b0;
            sdrv = 1'b0;
            sw++;
          end else begin
            ubus_wait = 1'b0;
            ubus_error = e_sched[sb];
            sdrv = !wr;
            sval = rbytes[8*sb +: 8];
            sb++;
            sw = 0;
          end
        end else begin
          ubus_wait = 1'b0;
          ubus_error = 1'b0;
          sdrv = 1'b0;
        end
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout: got no rsp_valid in 300 cycles");
    end
    cmd_valid = 1'b0;
    ubus_wait = 1'b0;
    ubus_error = 1'b0;
    sdrv = 1'b0;
    @(negedge clk);
    chk("back_idle", cmd_ready, 1);
    chk("single_pulse", rsp_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got hang expected finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] rd;
    logic [63:0] mrd;
    bit          er;
    bit          mer;
    int          cyc;
    int          mcyc;
    int          beats;
    int          seen;
    bit          wr;
    logic [1:0]  sz;

    vt[0] = '{1'b1, 16'h1234, 2'd0, 64'hA5, 64'h0,
              0, 0, -1, 2, 0, 64'h0, 1'b0, 1};
    vt[1] = '{1'b0, 16'h0040, 2'd3, 64'h0, 64'h0807060504030201,
              3, 2, -1, 0, 0, 64'h0807060504030201, 1'b0, 10};
    vt[2] = '{1'b1, 16'h0100, 2'd2, 64'hDEADBEEF, 64'h0,
              0, 0, 1, 1, 0, 64'h0, 1'b1, 4};
    vt[3] = '{1'b0, 16'h0200, 2'd1, 64'h0, 64'hBBAA,
              0, 16, -1, 0, 0, 64'h0, 1'b1, 17};
    vt[4] = '{1'b1, 16'h0300, 2'd0, 64'h5A, 64'h0,
              0, 0, -1, 0, 3, 64'h0, 1'b0, 1};
    vt[5] = '{1'b0, 16'h0400, 2'd0, 64'h0, 64'h77,
              0, 15, -1, 1, 0, 64'h77, 1'b0, 16};
    vt[6] = '{1'b0, 16'h0500, 2'd2, 64'h0, 64'h44332211,
              3, 16, -1, 0, 1, 64'h332211, 1'b1, 20};

    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr = '0;
    cmd_size = '0;
    cmd_wdata = '0;
    ubus_gnt = 1'b0;
    ubus_start = 1'b0;
    ubus_wait = 1'b0;
    ubus_error = 1'b0;
    sdrv = 1'b0;
    sval = '0;
    #1;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_error", rsp_error, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_req", ubus_req, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vt[v]) begin
      for (int b = 0; b < 8; b++) begin
        w_sched[b] = (b == vt[v].wbeat) ? vt[v].wlen : 0;
        e_sched[b] = (b == vt[v].ebeat);
      end
      model_xfer(vt[v].wr, vt[v].size, vt[v].wdata, vt[v].rbytes,
                 mrd, mer, mcyc);
      run_xfer(vt[v].wr, vt[v].addr, vt[v].size, vt[v].wdata,
               vt[v].rbytes, vt[v].gdly, vt[v].gonly, 1'b0,
               rd, er, cyc);
      chk($sformatf("vec%0d_rdata", v), rd, vt[v].erd);
      chk($sformatf("vec%0d_error", v), er, vt[v].eerr);
      chk($sformatf("vec%0d_cycles", v), cyc, vt[v].ecyc);
    end

    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr = 16'h0A0A;
    cmd_size = 2'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rreq_req", ubus_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rreq_req_async", ubus_req, 0);
    chk("rreq_ready_async", cmd_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rreq_ready_after", cmd_ready, 1);

    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr = 16'h0B0B;
    cmd_size = 2'd2;
    cmd_wdata = 64'hC3C3C3C3;
    @(negedge clk);
    cmd_valid = 1'b0;
    ubus_gnt = 1'b1;
    ubus_start = 1'b1;
    @(negedge clk);
    ubus_gnt = 1'b0;
    ubus_start = 1'b0;
    ubus_wait = 1'b1;
    @(negedge clk);
    chk("rdat_pre", ubus_data, 8'hC3);
    #2 rst_n = 1'b0;
    #1;
    chk("rdat_ready_async", cmd_ready, 1);
    chk("rdat_req_async", ubus_req, 0);
    chk("rdat_valid_async", rsp_valid, 0);
    sdrv = 1'b1;
    sval = 8'h3C;
    #1;
    chk("rdat_released", ubus_data, 8'h3C);
    sdrv = 1'b0;
    ubus_wait = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("rdat_no_resp", seen, 0);
    chk("rdat_ready_after", cmd_ready, 1);

    for (int t = 0; t < 24; t++) begin
      wr = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      beats = 1 << sz;
      for (int b = 0; b < 8; b++) begin
        w_sched[b] = $urandom_range(0, 3);
        e_sched[b] = ($urandom_range(0, 5) == 0);
      end
      if ($urandom_range(0, 5) == 0)
        w_sched[$urandom_range(0, beats - 1)] = MW + $urandom_range(0, 3);
      cmd_addr = 16'($urandom);
      cmd_wdata = {32'($urandom), 32'($urandom)};
      mrd = {32'($urandom), 32'($urandom)};
      rd = cmd_wdata;
      model_xfer(wr, sz, rd, mrd, rd, mer, mcyc);
      begin
        logic [63:0] rb;
        logic [63:0] wd;
        logic [15:0] ad;
        logic [63:0] exp_rd;
        exp_rd = rd;
        rb = mrd;
        wd = cmd_wdata;
        ad = cmd_addr;
        run_xfer(wr, ad, sz, wd, rb, $urandom_range(0, 3),
                 $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                 rd, er, cyc);
        chk($sformatf("rnd%0d_rdata", t), rd, exp_rd);
        chk($sformatf("rnd%0d_error", t), er, mer);
        chk($sformatf("rnd%0d_cycles", t), cyc, mcyc);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
